// File: rtl/fetch_window_sequencer.sv
// fetch_window_sequencer: byte-queue fetch window for the decoder, with an optional DECODE_STATS_EN macro that adds inst/stall counters
module fetch_window_sequencer #(
  parameter int QUEUE_BYTES = 32,
  parameter int WINDOW_BYTES = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry_pc,
  output logic                      fetch_req,
  output logic [63:0]               fetch_addr,
  input  logic                      fetch_ack,
  input  logic [63:0]               fetch_data,
  output logic [0:WINDOW_BYTES*8-1] window,
  output logic                      window_valid,
  output logic [63:0]               decode_pc,
  input  logic                      decode_fire,
  input  logic [3:0]                decode_bytes,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]               inst_count,
  output logic [31:0]               stall_count
`endif
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [QUEUE_BYTES-1:0][7:0] mem_q, mem_d;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0] skip_q, skip_d;
  logic [63:0] fa_q, fa_d, addr_q, addr_d, pc_q, pc_d;
  logic req_q, req_d;
  logic ack_v, holding, enq, cons;
  logic [3:0] enq_n;
  always_comb begin
    ack_v = req_q && fetch_ack;
    holding = req_q && !fetch_ack;
    enq = ack_v && state_q == RUN && !redirect;
    cons = decode_fire && window_valid && decode_bytes != 4'd0 && !redirect;
    enq_n = 4'd8 - {1'b0, skip_q};
    mem_d = mem_q;
    for (int k = 0; k < 8; k++)
      if (enq && k >= int'(skip_q)) mem_d[tail_q + PW'(k) - PW'(skip_q)] = fetch_data[8*k +: 8];
    head_d = redirect ? tail_q : cons ? head_q + PW'(decode_bytes) : head_q;
    tail_d = enq ? tail_q + PW'(enq_n) : tail_q;
    count_d = redirect ? '0 : count_q + (enq ? CW'(enq_n) : '0) - (cons ? CW'(decode_bytes) : '0);
    pc_d = redirect ? redirect_pc : cons ? pc_q + 64'(decode_bytes) : pc_q;
    skip_d = redirect ? redirect_pc[2:0] : enq ? 3'd0 : skip_q;
    fa_d = redirect ? {redirect_pc[63:3], 3'b0} : enq ? fa_q + 64'd8 : fa_q;
    state_d = redirect ? (holding ? DRAIN : RUN) : (state_q == IDLE || (state_q == DRAIN && ack_v)) ? RUN : state_q;
    req_d = holding || (state_d == RUN && count_d <= CW'(QUEUE_BYTES - 8));
    addr_d = holding ? addr_q : fa_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      skip_q <= entry_pc[2:0];
      fa_q <= {entry_pc[63:3], 3'b0};
      addr_q <= {entry_pc[63:3], 3'b0};
      pc_q <= entry_pc;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      skip_q <= skip_d;
      fa_q <= fa_d;
      addr_q <= addr_d;
      pc_q <= pc_d;
      req_q <= req_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++)
      window[i*8 +: 8] = (CW'(i) < count_q) ? mem_q[head_q + PW'(i)] : 8'd0;
  end
  assign window_valid = count_q >= CW'(WINDOW_BYTES);
  assign fetch_req = req_q;
  assign fetch_addr = addr_q;
  assign decode_pc = pc_q;
`ifdef DECODE_STATS_EN
  logic [31:0] inst_q, inst_d, stall_q, stall_d;
  always_comb begin
    inst_d = (cons && inst_q != '1) ? inst_q + 32'd1 : inst_q;
    stall_d = (state_q != IDLE && !window_valid && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= '0;
      stall_q <= '0;
    end else begin
      inst_q <= inst_d;
      stall_q <= stall_d;
    end
  end
  assign inst_count = inst_q;
  assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_fetch_window_sequencer.sv
// tb_fetch_window_sequencer: directed scenario bench; memory byte at address a is a[7:0]
module tb_fetch_window_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] entry_pc;
  logic fetch_req;
  logic [63:0] fetch_addr;
  logic fetch_ack;
  logic [63:0] fetch_data;
  logic [0:119] window;
  logic window_valid;
  logic [63:0] decode_pc;
  logic decode_fire;
  logic [3:0] decode_bytes;
  logic redirect;
  logic [63:0] redirect_pc;
`ifdef DECODE_STATS_EN
  logic [31:0] inst_count, stall_count;
`endif
  int total = 0;
  int bad = 0;
  int nacks;
  logic [63:0] a0, a1, last_ack, exp_pc, a_hold;
  fetch_window_sequencer dut (
    .clk(clk),
    .reset(reset),
    .entry_pc(entry_pc),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .fetch_data(fetch_data),
    .window(window),
    .window_valid(window_valid),
    .decode_pc(decode_pc),
    .decode_fire(decode_fire),
    .decode_bytes(decode_bytes),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef DECODE_STATS_EN
    ,
    .inst_count(inst_count),
    .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] word_at(input logic [63:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(a + 64'(k));
    return w;
  endfunction
  function automatic logic [0:119] exp_win(input logic [63:0] pc, input int n);
    logic [0:119] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i*8 +: 8] = 8'(pc + 64'(i));
    return e;
  endfunction
  task automatic cyc(input bit ack_en);
    fetch_ack = ack_en;
    fetch_data = word_at(fetch_addr);
    if (ack_en && fetch_req && !reset) begin
      if (nacks == 0) a0 = fetch_addr;
      if (nacks == 1) a1 = fetch_addr;
      nacks++;
      last_ack = fetch_addr;
    end
    @(posedge clk);
    #1;
    fetch_ack = 1'b0;
    decode_fire = 1'b0;
    redirect = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    entry_pc = 64'h1000;
    cyc(0);
    cyc(0);
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0d want 0", fetch_req); end
    total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0d want 0", window_valid); end
    total++; if (window !== '0) begin bad++; $display("FAIL reset_window: got %h want 0", window); end
    total++; if (decode_pc !== 64'h1000) begin bad++; $display("FAIL reset_pc: got %h want 1000", decode_pc); end
    reset = 1'b0;
  endtask
  task automatic test_fill;
    nacks = 0;
    a0 = '1;
    a1 = '1;
    for (int i = 0; i < 10 && !window_valid; i++) cyc(1);
    total++; if (nacks != 2) begin bad++; $display("FAIL fill_acks: got %0d want 2", nacks); end
    total++; if (a0 !== 64'h1000) begin bad++; $display("FAIL fill_addr0: got %h want 1000", a0); end
    total++; if (a1 !== 64'h1008) begin bad++; $display("FAIL fill_addr1: got %h want 1008", a1); end
    total++; if (window_valid !== 1'b1) begin bad++; $display("FAIL fill_valid: got %0d want 1", window_valid); end
    total++; if (window !== exp_win(64'h1000, 15)) begin bad++; $display("FAIL fill_window: got %h want %h", window, exp_win(64'h1000, 15)); end
    total++; if (decode_pc !== 64'h1000) begin bad++; $display("FAIL fill_pc: got %h want 1000", decode_pc); end
  endtask
  task automatic test_consume;
    decode_fire = 1'b1;
    decode_bytes = 4'd3;
    cyc(0);
    total++; if (decode_pc !== 64'h1003) begin bad++; $display("FAIL consume_pc: got %h want 1003", decode_pc); end
    total++; if (window !== exp_win(64'h1003, 13)) begin bad++; $display("FAIL consume_window: got %h want %h", window, exp_win(64'h1003, 13)); end
    total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL consume_valid: got %0d want 0", window_valid); end
    decode_fire = 1'b1;
    decode_bytes = 4'd2;
    cyc(0);
    total++; if (decode_pc !== 64'h1003) begin bad++; $display("FAIL consume_invalid_pc: got %h want 1003", decode_pc); end
  endtask
  task automatic test_wrap;
    logic v;
    exp_pc = 64'h1003;
    for (int i = 0; i < 30; i++) begin
      decode_fire = 1'b1;
      decode_bytes = 4'd15;
      v = window_valid;
      if (v) begin
        total++; if (window !== exp_win(exp_pc, 15)) begin bad++; $display("FAIL wrap_window: got %h want %h", window, exp_win(exp_pc, 15)); end
        total++; if (decode_pc !== exp_pc) begin bad++; $display("FAIL wrap_pc: got %h want %h", decode_pc, exp_pc); end
      end
      cyc(1);
      if (v) exp_pc += 64'd15;
    end
    total++; if (exp_pc - 64'h1003 < 64'd60) begin bad++; $display("FAIL wrap_progress: got %0d want >=60", exp_pc - 64'h1003); end
  endtask
  task automatic test_full;
    for (int i = 0; i < 20 && fetch_req; i++) cyc(1);
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL full_reach: got %0d want 0", fetch_req); end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL full_req_idle: got %0d want 0", fetch_req); end
      total++; if (window !== exp_win(exp_pc, 15)) begin bad++; $display("FAIL full_window: got %h want %h", window, exp_win(exp_pc, 15)); end
    end
    decode_fire = 1'b1;
    decode_bytes = 4'd0;
    cyc(0);
    total++; if (decode_pc !== exp_pc) begin bad++; $display("FAIL full_zero_pc: got %h want %h", decode_pc, exp_pc); end
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL full_zero_req: got %0d want 0", fetch_req); end
    decode_fire = 1'b1;
    decode_bytes = 4'd15;
    cyc(0);
    exp_pc += 64'd15;
    total++; if (fetch_req !== 1'b1) begin bad++; $display("FAIL full_reenable: got %0d want 1", fetch_req); end
    total++; if (decode_pc !== exp_pc) begin bad++; $display("FAIL full_pc: got %h want %h", decode_pc, exp_pc); end
    total++; if (fetch_addr !== last_ack + 64'd8) begin bad++; $display("FAIL full_addr: got %h want %h", fetch_addr, last_ack + 64'd8); end
  endtask
  task automatic test_redirect_drain;
    a_hold = fetch_addr;
    redirect = 1'b1;
    redirect_pc = 64'h3000;
    cyc(0);
    total++; if (fetch_req !== 1'b1 || fetch_addr !== a_hold) begin bad++; $display("FAIL drain_hold: got req=%0d addr=%h want req=1 addr=%h", fetch_req, fetch_addr, a_hold); end
    total++; if (decode_pc !== 64'h3000) begin bad++; $display("FAIL drain_pc: got %h want 3000", decode_pc); end
    total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %0d want 0", window_valid); end
    redirect = 1'b1;
    redirect_pc = 64'h3003;
    cyc(0);
    total++; if (fetch_addr !== a_hold) begin bad++; $display("FAIL drain_hold2: got %h want %h", fetch_addr, a_hold); end
    total++; if (decode_pc !== 64'h3003) begin bad++; $display("FAIL drain_pc2: got %h want 3003", decode_pc); end
    cyc(1);
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h3000) begin bad++; $display("FAIL drain_reissue: got req=%0d addr=%h want req=1 addr=3000", fetch_req, fetch_addr); end
    nacks = 0;
    for (int i = 0; i < 10 && !window_valid; i++) cyc(1);
    total++; if (nacks != 3) begin bad++; $display("FAIL drain_acks: got %0d want 3", nacks); end
    total++; if (window !== exp_win(64'h3003, 15)) begin bad++; $display("FAIL drain_window: got %h want %h", window, exp_win(64'h3003, 15)); end
  endtask
  task automatic test_redirect_idle;
    for (int i = 0; i < 20 && fetch_req; i++) cyc(1);
    redirect = 1'b1;
    redirect_pc = 64'h2005;
    cyc(0);
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h2000) begin bad++; $display("FAIL redir_req: got req=%0d addr=%h want req=1 addr=2000", fetch_req, fetch_addr); end
    total++; if (decode_pc !== 64'h2005) begin bad++; $display("FAIL redir_pc: got %h want 2005", decode_pc); end
    total++; if (window !== '0) begin bad++; $display("FAIL redir_flush: got %h want 0", window); end
    nacks = 0;
    for (int i = 0; i < 10 && !window_valid; i++) cyc(1);
    total++; if (nacks != 3) begin bad++; $display("FAIL redir_acks: got %0d want 3", nacks); end
    total++; if (window !== exp_win(64'h2005, 15)) begin bad++; $display("FAIL redir_window: got %h want %h", window, exp_win(64'h2005, 15)); end
  endtask
  task automatic test_reset_mid;
    reset = 1'b1;
    entry_pc = 64'h4000;
    cyc(1);
    total++; if (fetch_req !== 1'b0 || window_valid !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got req=%0d valid=%0d want 0 0", fetch_req, window_valid); end
    total++; if (decode_pc !== 64'h4000) begin bad++; $display("FAIL rmid_pc: got %h want 4000", decode_pc); end
    reset = 1'b0;
    cyc(0);
    cyc(1);
    cyc(1);
    total++; if (window !== exp_win(64'h4000, 15)) begin bad++; $display("FAIL rmid_window: got %h want %h", window, exp_win(64'h4000, 15)); end
    decode_fire = 1'b1; decode_bytes = 4'd1; cyc(1);
    decode_fire = 1'b1; decode_bytes = 4'd4; cyc(0);
    decode_fire = 1'b1; decode_bytes = 4'd1; cyc(0);
    decode_fire = 1'b1; decode_bytes = 4'd1; cyc(0);
    decode_fire = 1'b1; decode_bytes = 4'd3; cyc(0);
    total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL rmid_starve: got %0d want 0", window_valid); end
    cyc(0);
    total++; if (decode_pc !== 64'h400A) begin bad++; $display("FAIL rmid_pc_end: got %h want 400a", decode_pc); end
`ifdef DECODE_STATS_EN
    total++; if (inst_count !== 32'd5) begin bad++; $display("FAIL stats_inst: got %0d want 5", inst_count); end
    total++; if (stall_count !== 32'd3) begin bad++; $display("FAIL stats_stall: got %0d want 3", stall_count); end
`endif
  endtask
  initial begin
    reset = 1'b1;
    entry_pc = '0;
    fetch_ack = 1'b0;
    fetch_data = '0;
    decode_fire = 1'b0;
    decode_bytes = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    nacks = 0;
    last_ack = '0;
    test_reset;
    test_fill;
    test_consume;
    test_wrap;
    test_full;
    test_redirect_drain;
    test_redirect_idle;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
